// File: rtl/exec_seq_if.sv
// Bundle between the instruction source, the exec_seq sequencer and the 4x8 register file.
// Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready are both high;
// the source holds instr stable while instr_valid is high and not yet accepted.
interface exec_seq_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr;
    logic [ADDR_W-1:0] raddr0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wren;
    logic              done;
    logic              busy;
    logic              flag_zero;
    logic              flag_carry;

    // master is the environment: instruction source plus register file read data
    modport master (
        output instr_valid, instr, rdata0, rdata1,
        input  instr_ready, raddr0, raddr1, waddr, wdata, wren, done, busy,
               flag_zero, flag_carry
    );

    modport slave (
        input  instr_valid, instr, rdata0, rdata1,
        output instr_ready, raddr0, raddr1, waddr, wdata, wren, done, busy,
               flag_zero, flag_carry
    );
endinterface

// File: rtl/exec_seq.sv
// Four-state instruction sequencer and 8-bit ALU feeding the 4x8 register file write port.
// Every output is a register; write-back data settles one cycle before the wren pulse.
module exec_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    exec_seq_if.slave  bus,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LI   = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    state_t            state_q, state_d;
    logic [7:0]        instr_q, instr_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              wren_q, wren_d;
    logic              done_q, done_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic [ADDR_W-1:0] raddr0_q, raddr0_d;
    logic [ADDR_W-1:0] raddr1_q, raddr1_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic [1:0]        op;
    logic [DATA_W-1:0] opa, opb;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign accept = bus.instr_valid && ready_q;
    assign op     = instr_q[7:6];
    assign opa    = bus.rdata0;
    assign opb    = bus.rdata1;

    // Operands are read while the latched read addresses are on the register file,
    // so rd == rs / rd == rt sees the old register value.
    always_comb begin
        sum        = {1'b0, opa} + {1'b0, opb};
        diff       = opa - opb;
        alu_result = '0;
        alu_carry  = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_result = sum[DATA_W-1:0];
                alu_carry  = sum[DATA_W];
            end
            OP_SUB: begin
                alu_result = diff;
                alu_carry  = (opa < opb);
            end
            OP_LI: begin
                alu_result = DATA_W'(instr_q[3:0]);
                alu_carry  = 1'b0;
            end
            OP_NAND: begin
                alu_result = ~(opa & opb);
                alu_carry  = 1'b0;
            end
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d  = instr_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        raddr0_d = raddr0_q;
        raddr1_d = raddr1_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d  = bus.instr;
                    raddr0_d = ADDR_W'(bus.instr[3:2]);
                    raddr1_d = ADDR_W'(bus.instr[1:0]);
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            DECODE: begin
                // Result registers become valid on entry to EXEC, a full cycle ahead of wren.
                wdata_d = alu_result;
                waddr_d = ADDR_W'(instr_q[5:4]);
                zero_d  = (alu_result == '0);
                carry_d = alu_carry;
            end
            EXEC: begin
                wren_d = 1'b1;
                done_d = 1'b1;
            end
            WB: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            raddr0_q <= '0;
            raddr1_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            wren_q   <= wren_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            raddr0_q <= raddr0_d;
            raddr1_q <= raddr1_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.busy        = busy_q;
    assign bus.wren        = wren_q;
    assign bus.done        = done_q;
    assign bus.flag_zero   = zero_q;
    assign bus.flag_carry  = carry_q;
    assign bus.raddr0      = raddr0_q;
    assign bus.raddr1      = raddr1_q;
    assign bus.waddr       = waddr_q;
    assign bus.wdata       = wdata_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: directed vector table plus reset and back-pressure sequences.
module tb_exec_seq;

    logic       clk;
    logic       rst;
    logic [1:0] state_o;
    logic [7:0] rf [4];

    int checks;
    int errors;

    exec_seq_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    exec_seq #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    // Register file model: preloaded by the bench, combinational reads, no write-back.
    assign bus.rdata0 = rf[bus.raddr0];
    assign bus.rdata1 = rf[bus.raddr1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  instr;
        logic [31:0] regs;   // {r3, r2, r1, r0}
        logic [1:0]  waddr;
        logic [7:0]  wdata;
        logic        zero;
        logic        carry;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_rf(input logic [31:0] regs);
        rf[0] = regs[7:0];
        rf[1] = regs[15:8];
        rf[2] = regs[23:16];
        rf[3] = regs[31:24];
    endtask

    // Waits (bounded) for instr_ready, then completes one handshake; returns at the
    // negedge after the accepting edge (DUT in DECODE).
    task automatic send(input logic [7:0] ins, input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " ready_before_accept"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = ~ins;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        load_rf(v.regs);
        send(v.instr, tag);
        chk({tag, " decode_busy"},  32'(bus.busy),        32'd1);
        chk({tag, " decode_ready"}, 32'(bus.instr_ready), 32'd0);
        chk({tag, " decode_wren"},  32'(bus.wren),        32'd0);
        if (v.instr[7:6] != 2'b10) begin
            chk({tag, " raddr0"}, 32'(bus.raddr0), 32'(v.instr[3:2]));
            chk({tag, " raddr1"}, 32'(bus.raddr1), 32'(v.instr[1:0]));
        end
        @(negedge clk);
        chk({tag, " exec_wren"},  32'(bus.wren),       32'd0);
        chk({tag, " exec_waddr"}, 32'(bus.waddr),      32'(v.waddr));
        chk({tag, " exec_wdata"}, 32'(bus.wdata),      32'(v.wdata));
        chk({tag, " zero"},       32'(bus.flag_zero),  32'(v.zero));
        chk({tag, " carry"},      32'(bus.flag_carry), 32'(v.carry));
        @(negedge clk);
        chk({tag, " wb_wren"},  32'(bus.wren),  32'd1);
        chk({tag, " wb_done"},  32'(bus.done),  32'd1);
        chk({tag, " wb_waddr"}, 32'(bus.waddr), 32'(v.waddr));
        chk({tag, " wb_wdata"}, 32'(bus.wdata), 32'(v.wdata));
        @(negedge clk);
        chk({tag, " idle_wren"},  32'(bus.wren),        32'd0);
        chk({tag, " idle_done"},  32'(bus.done),        32'd0);
        chk({tag, " idle_ready"}, 32'(bus.instr_ready), 32'd1);
        chk({tag, " idle_busy"},  32'(bus.busy),        32'd0);
        chk({tag, " hold_waddr"}, 32'(bus.waddr),       32'(v.waddr));
        chk({tag, " hold_wdata"}, 32'(bus.wdata),       32'(v.wdata));
        chk({tag, " hold_zero"},  32'(bus.flag_zero),   32'(v.zero));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " ready"}, 32'(bus.instr_ready), 32'd1);
        chk({tag, " busy"},  32'(bus.busy),        32'd0);
        chk({tag, " wren"},  32'(bus.wren),        32'd0);
        chk({tag, " done"},  32'(bus.done),        32'd0);
        chk({tag, " waddr"}, 32'(bus.waddr),       32'd0);
        chk({tag, " wdata"}, 32'(bus.wdata),       32'd0);
        chk({tag, " zero"},  32'(bus.flag_zero),   32'd0);
        chk({tag, " carry"}, 32'(bus.flag_carry),  32'd0);
        chk({tag, " state"}, 32'(state_o),         32'd0);
    endtask

    logic [9:0] exp_q [$];
    logic       rdy_h [16];
    logic       wren_h [16];
    logic [1:0] wa_h [16];
    logic [7:0] wd_h [16];
    int         acc_c [2];

    initial begin
        int n_acc;
        int n_wren;
        int quiet;
        logic [7:0] bp_instr [2];
        logic [9:0] e;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 8'h00;
        load_rf(32'h0);

        //                instr  regs {r3,r2,r1,r0}  waddr wdata zero carry
        vecs[0] = '{8'h95, 32'h0000_0000, 2'd1, 8'h05, 1'b0, 1'b0}; // LI r1,5
        vecs[1] = '{8'h36, 32'h0064_C800, 2'd3, 8'h2C, 1'b0, 1'b1}; // ADD r3,r1,r2
        vecs[2] = '{8'h49, 32'h0064_C800, 2'd0, 8'h9C, 1'b0, 1'b1}; // SUB r0,r2,r1
        vecs[3] = '{8'h45, 32'h0064_C800, 2'd0, 8'h00, 1'b1, 1'b0}; // SUB r0,r1,r1
        vecs[4] = '{8'hE5, 32'h0064_C800, 2'd2, 8'h37, 1'b0, 1'b0}; // NAND r2,r1,r1
        vecs[5] = '{8'h00, 32'h0000_0080, 2'd0, 8'h00, 1'b1, 1'b1}; // ADD r0,r0,r0
        vecs[6] = '{8'hB0, 32'h0000_0000, 2'd3, 8'h00, 1'b1, 1'b0}; // LI r3,0
        vecs[7] = '{8'hDB, 32'hFFFF_0000, 2'd1, 8'h00, 1'b1, 1'b0}; // NAND r1,r2,r3
        vecs[8] = '{8'h6C, 32'h0500_0005, 2'd2, 8'h00, 1'b1, 1'b0}; // SUB r2,r3,r0 equal
        vecs[9] = '{8'h1B, 32'h01FF_0000, 2'd1, 8'h00, 1'b1, 1'b1}; // ADD r1,r2,r3 wrap

        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Two-cycle reset starting in DECODE; flags are nonzero beforehand.
        load_rf(32'h0064_C800);
        send(8'h36, "rst2");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("rst2");
        rst = 1'b0;
        n_wren = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.wren) n_wren++;
        end
        chk("rst2 no_wren_after", 32'(n_wren), 32'd0);

        // Reset seen at the edge leaving EXEC of NAND r2,r1,r1.
        send(8'hE5, "rst_exec");
        @(negedge clk);
        chk("rst_exec in_exec_wren", 32'(bus.wren), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("rst_exec");
        rst = 1'b0;
        n_wren = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.wren) n_wren++;
        end
        chk("rst_exec no_wren_after", 32'(n_wren), 32'd0);
        run_vec(vecs[0], "li_after_rst");

        // Back-pressure: instr_valid held high across two instructions.
        load_rf(32'h0020_1000);
        bp_instr[0] = 8'hA9;  // LI r2,9
        bp_instr[1] = 8'h16;  // ADD r1,r1,r2 -> 0x10 + 0x20
        exp_q.push_back({2'd2, 8'h09});
        exp_q.push_back({2'd1, 8'h30});
        n_acc = 0;
        acc_c[0] = 0;
        acc_c[1] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.instr_valid = (n_acc < 2);
            bus.instr       = bp_instr[(n_acc < 2) ? n_acc : 1];
            rdy_h[c]  = bus.instr_ready;
            wren_h[c] = bus.wren;
            wa_h[c]   = bus.waddr;
            wd_h[c]   = bus.wdata;
            if (bus.instr_ready && bus.instr_valid) begin
                if (n_acc < 2) acc_c[n_acc] = c;
                n_acc++;
            end
        end
        bus.instr_valid = 1'b0;
        chk("bp accept_count", 32'(n_acc), 32'd2);
        chk("bp accept_spacing", 32'(acc_c[1] - acc_c[0]), 32'd4);
        n_wren = 0;
        for (int c = 1; c < 15; c++) begin
            if (wren_h[c]) begin
                n_wren++;
                if (exp_q.size() == 0) begin
                    chk("bp extra_wren", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bp waddr",        32'(wa_h[c]),   32'(e[9:8]));
                    chk("bp wdata",        32'(wd_h[c]),   32'(e[7:0]));
                    chk("bp waddr_before", 32'(wa_h[c-1]), 32'(e[9:8]));
                    chk("bp wdata_before", 32'(wd_h[c-1]), 32'(e[7:0]));
                    chk("bp waddr_after",  32'(wa_h[c+1]), 32'(e[9:8]));
                    chk("bp wdata_after",  32'(wd_h[c+1]), 32'(e[7:0]));
                    chk("bp wren_width",   32'(wren_h[c+1]), 32'd0);
                    chk("bp ready_low_at_wren", 32'(rdy_h[c]), 32'd0);
                end
            end
        end
        chk("bp wren_count", 32'(n_wren), 32'd2);
        chk("bp wren_latency", 32'(wren_h[acc_c[0] + 3]), 32'd1);
        chk("bp queue_drained", 32'(exp_q.size()), 32'd0);

        quiet = 0;
        repeat (2) @(negedge clk);
        if (!bus.busy) quiet = 1;
        chk("final idle", 32'(quiet), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
